// File: rtl/reset_sequencer_pkg.sv
// Shared state codes, default timing values and counter sizing for the reset sequencer.
package reset_sequencer_pkg;

    localparam logic [2:0] S_SYNC     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_CHOLD    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_CPU_HOLD        = 4;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-clear, sync-release flop chain; usable for any asynchronous active-low input.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_out,
    output logic sync_pre
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    // sync_pre is the value sync_out takes on the next edge
    assign sync_out = chain[STAGES-1];
    assign sync_pre = chain[STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Board-button reset fan-out: async assertion, synchronised/debounced release,
// peripherals first then the CPU core, plus a CPU-requested soft re-sequence.
//
// state      | meaning
// S_SYNC     | button released, waiting for the synchroniser to fill
// S_DEBOUNCE | counting synchronised-high cycles before releasing peripherals
// S_CHOLD    | peripherals running, holding the CPU core in reset
// S_RUN      | everything out of reset; soft_rst_req accepted here only
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CPU_HOLD        = DEF_CPU_HOLD
) (
    input  logic       clk,
    input  logic       btn0_n,
    input  logic       soft_rst_req,
    output logic       rst_periph_n,
    output logic       rst_cpu_n,
    output logic       rst_done,
    output logic [2:0] phase
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, CPU_HOLD);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CPU_HOLD - 1);

    logic             sync_out;
    logic             sync_pre;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             periph_nxt;
    logic             cpu_nxt;
    logic             done_nxt;

    reset_sync #(
        .STAGES(SYNC_STAGES)
    ) u_btn_sync (
        .clk     (clk),
        .rst_n   (btn0_n),
        .sync_out(sync_out),
        .sync_pre(sync_pre)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        periph_nxt = rst_periph_n;
        cpu_nxt    = rst_cpu_n;
        done_nxt   = 1'b0;
        case (state)
            // look one stage ahead so the move coincides with sync_out rising
            S_SYNC: begin
                if (sync_pre) begin
                    state_nxt = S_DEBOUNCE;
                    cnt_nxt   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!sync_out) begin
                    state_nxt = S_SYNC;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = S_CHOLD;
                    cnt_nxt    = '0;
                    periph_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CHOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    cpu_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (soft_rst_req) begin
                    state_nxt  = S_DEBOUNCE;
                    cnt_nxt    = '0;
                    periph_nxt = 1'b0;
                    cpu_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt  = S_SYNC;
                cnt_nxt    = '0;
                periph_nxt = 1'b0;
                cpu_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge btn0_n) begin
        if (!btn0_n) begin
            state        <= S_SYNC;
            cnt          <= '0;
            rst_periph_n <= 1'b0;
            rst_cpu_n    <= 1'b0;
            rst_done     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rst_periph_n <= periph_nxt;
            rst_cpu_n    <= cpu_nxt;
            rst_done     <= done_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a short-timing instance, checked
// against an edge-counting model of the release schedule.
module tb_reset_sequencer;

    localparam int SS0 = 2, D0 = 16, H0 = 4;
    localparam int SS1 = 3, D1 = 1,  H1 = 1;

    logic       clk = 1'b0;
    logic       btn0_n, btn1_n, soft0, soft1;
    logic       periph0, cpu0, done0, periph1, cpu1, done1;
    logic [2:0] phase0, phase1;
    logic [5:0] obs0, obs1;

    int errors = 0;
    int checks = 0;

    // model: boot=1 counts edges since button release, boot=0 counts edges since soft request
    bit m0_boot = 1'b1, m1_boot = 1'b1;
    int m0_cnt = 0, m1_cnt = 0;

    always #5 clk = ~clk;

    reset_sequencer dut0 (
        .clk(clk), .btn0_n(btn0_n), .soft_rst_req(soft0),
        .rst_periph_n(periph0), .rst_cpu_n(cpu0), .rst_done(done0), .phase(phase0)
    );

    reset_sequencer #(
        .SYNC_STAGES(SS1), .DEBOUNCE_CYCLES(D1), .CPU_HOLD(H1)
    ) dut1 (
        .clk(clk), .btn0_n(btn1_n), .soft_rst_req(soft1),
        .rst_periph_n(periph1), .rst_cpu_n(cpu1), .rst_done(done1), .phase(phase1)
    );

    assign obs0 = {periph0, cpu0, done0, phase0};
    assign obs1 = {periph1, cpu1, done1, phase1};

    function automatic logic [5:0] exp_out(input bit btn, input bit boot, input int cnt,
                                           input int ss, input int d, input int h);
        int base;
        logic [2:0] ph;
        if (!btn) return 6'b0;
        base = boot ? ss : 0;
        if (boot && cnt < ss)      ph = 3'd0;
        else if (cnt < base + d)     ph = 3'd1;
        else if (cnt < base + d + h) ph = 3'd2;
        else                         ph = 3'd3;
        return {cnt >= base + d, cnt >= base + d + h, cnt == base + d + h, ph};
    endfunction

    task automatic tick();
        logic [5:0] e;
        @(posedge clk);
        e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
        if (!btn0_n) begin m0_boot = 1'b1; m0_cnt = 0; end
        else if (soft0 && e[2:0] == 3'd3) begin m0_boot = 1'b0; m0_cnt = 0; end
        else if (m0_cnt < 100000) m0_cnt++;
        e = exp_out(btn1_n, m1_boot, m1_cnt, SS1, D1, H1);
        if (!btn1_n) begin m1_boot = 1'b1; m1_cnt = 0; end
        else if (soft1 && e[2:0] == 3'd3) begin m1_boot = 1'b0; m1_cnt = 0; end
        else if (m1_cnt < 100000) m1_cnt++;
        @(negedge clk);
    endtask

    task automatic assert_btn0();
        btn0_n = 1'b0; m0_boot = 1'b1; m0_cnt = 0;
    endtask

    task automatic assert_btn1();
        btn1_n = 1'b0; m1_boot = 1'b1; m1_cnt = 0;
    endtask

    task automatic test_reset();
        logic [5:0] e;
        int done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL reset_hold cyc%0d: got %b expected %b", i, obs0, e); end
        end
        btn0_n = 1'b1;
        btn1_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done0) done_cnt++;
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL reset_release edge%0d: got %b expected %b", i, obs0, e); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL reset_done_pulses: got %0d expected 1", done_cnt); end
        checks++;
        if (phase0 !== 3'd3) begin errors++; $display("FAIL reset_final_phase: got %0d expected 3", phase0); end
    endtask

    task automatic test_async_assert();
        logic [5:0] e;
        #2 assert_btn0();
        #1;
        checks++;
        if (obs0 !== 6'b0) begin errors++; $display("FAIL async_assert: got %b expected 000000", obs0); end
        for (int i = 0; i < 3; i++) tick();
        btn0_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL async_rerelease edge%0d: got %b expected %b", i, obs0, e); end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] e;
        assert_btn0();
        for (int i = 0; i < 3; i++) tick();
        btn0_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        #1 assert_btn0();
        #1;
        checks++;
        if (obs0 !== 6'b0) begin errors++; $display("FAIL bounce_low: got %b expected 000000", obs0); end
        #2 btn0_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL bounce_release edge%0d: got %b expected %b", i, obs0, e); end
        end
    endtask

    task automatic test_chold_abort();
        logic [5:0] e;
        int done_cnt = 0;
        assert_btn0();
        for (int i = 0; i < 3; i++) tick();
        btn0_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (phase0 !== 3'd2) begin errors++; $display("FAIL chold_reached: got phase %0d expected 2", phase0); end
        #2 assert_btn0();
        #1;
        checks++;
        if (obs0 !== 6'b0) begin errors++; $display("FAIL chold_abort: got %b expected 000000", obs0); end
        for (int i = 0; i < 4; i++) begin tick(); if (done0) done_cnt++; end
        btn0_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done0) done_cnt++;
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL chold_rerun edge%0d: got %b expected %b", i, obs0, e); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL chold_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_soft();
        logic [5:0] e;
        int done_cnt = 0;
        soft0 = 1'b1;
        tick();
        soft0 = 1'b0;
        checks++;
        if (obs0 !== 6'b000001) begin errors++; $display("FAIL soft_assert: got %b expected 000001", obs0); end
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (done0) done_cnt++;
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL soft_release k+%0d: got %b expected %b", i, obs0, e); end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL soft_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_soft_held();
        logic [5:0] e;
        int done_cnt = 0;
        assert_btn0();
        for (int i = 0; i < 2; i++) tick();
        btn0_n = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        soft0 = 1'b1;
        for (int i = 20; i <= 47; i++) begin
            tick();
            if (i == 23) soft0 = 1'b0;
            if (done0) done_cnt++;
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL soft_held edge%0d: got %b expected %b", i, obs0, e); end
        end
        checks++;
        if (done_cnt != 2) begin errors++; $display("FAIL soft_held_pulses: got %0d expected 2", done_cnt); end
    endtask

    task automatic test_params();
        logic [5:0] e;
        int pedge = 0, cedge = 0;
        assert_btn1();
        for (int i = 0; i < 2; i++) tick();
        btn1_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (periph1 && pedge == 0) pedge = i;
            if (cpu1 && cedge == 0) cedge = i;
            e = exp_out(btn1_n, m1_boot, m1_cnt, SS1, D1, H1);
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL params edge%0d: got %b expected %b", i, obs1, e); end
        end
        checks++;
        if (pedge != 4) begin errors++; $display("FAIL params_periph_edge: got %0d expected 4", pedge); end
        checks++;
        if (cedge != 5) begin errors++; $display("FAIL params_cpu_edge: got %0d expected 5", cedge); end
    endtask

    task automatic test_random();
        logic [5:0] e;
        int hold0 = 0, hold1 = 0;
        for (int i = 0; i < 500; i++) begin
            if (hold0 > 0) begin
                hold0--;
                if (hold0 == 0) btn0_n = 1'b1;
            end else if ($urandom_range(0, 49) == 0) begin
                assert_btn0();
                hold0 = $urandom_range(1, 4);
            end else if ($urandom_range(0, 29) == 0) begin
                #1 assert_btn0();
                #1;
                checks++;
                if (obs0 !== 6'b0) begin errors++; $display("FAIL rand_glitch it%0d: got %b expected 000000", i, obs0); end
                #1 btn0_n = 1'b1;
            end
            if (hold1 > 0) begin
                hold1--;
                if (hold1 == 0) btn1_n = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                assert_btn1();
                hold1 = $urandom_range(1, 3);
            end
            soft0 = ($urandom_range(0, 7) == 0);
            soft1 = ($urandom_range(0, 3) == 0);
            tick();
            e = exp_out(btn0_n, m0_boot, m0_cnt, SS0, D0, H0);
            checks++;
            if (obs0 !== e) begin errors++; $display("FAIL rand_dut0 it%0d: got %b expected %b", i, obs0, e); end
            e = exp_out(btn1_n, m1_boot, m1_cnt, SS1, D1, H1);
            checks++;
            if (obs1 !== e) begin errors++; $display("FAIL rand_dut1 it%0d: got %b expected %b", i, obs1, e); end
        end
        soft0 = 1'b0;
        soft1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        btn0_n = 1'b1;
        btn1_n = 1'b1;
        soft0  = 1'b0;
        soft1  = 1'b0;
        #1;
        assert_btn0();
        assert_btn1();
        @(negedge clk);
        test_reset();
        test_async_assert();
        test_bounce();
        test_chold_abort();
        test_soft();
        test_soft_held();
        test_params();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
